// File: rtl/mmio_bridge_pkg.sv
// Shared types for the MMIO AXI4 -> AXI4-Lite bridge: burst encodings,
// response codes, FSM states and the write-response merge rule.
package mmio_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_RESP = 3'd5,
    ST_WR_B    = 3'd6
  } state_e;

  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } prio_e;

  // Encodings are ordered by severity, so the worst response is the larger one.
  function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] resp);
    return (resp > acc) ? resp : acc;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts.
// The reserved burst type behaves as INCR.
module axi_burst_addr_gen
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] seq;

  always_comb begin
    incr = ADDR_W'(1) << size_i;
    span = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
    mask = span - ADDR_W'(1);
    seq  = addr_i + incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (seq & mask);
      default:     next_addr_o = seq;
    endcase
  end

endmodule

// File: rtl/mmio_axi4lite_bridge.sv
// Splits AXI4 bursts from the core MMIO port into single AXI4-Lite beats,
// one lite transaction outstanding at a time, and rebuilds AXI4 responses.
module mmio_axi4lite_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  input  logic [ID_W-1:0]   s_ar_id,
  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [7:0]        s_ar_len,
  input  logic [2:0]        s_ar_size,
  input  logic [1:0]        s_ar_burst,
  output logic              s_r_valid,
  input  logic              s_r_ready,
  output logic [ID_W-1:0]   s_r_id,
  output logic [DATA_W-1:0] s_r_data,
  output logic [1:0]        s_r_resp,
  output logic              s_r_last,
  input  logic              s_aw_valid,
  output logic              s_aw_ready,
  input  logic [ID_W-1:0]   s_aw_id,
  input  logic [ADDR_W-1:0] s_aw_addr,
  input  logic [7:0]        s_aw_len,
  input  logic [2:0]        s_aw_size,
  input  logic [1:0]        s_aw_burst,
  input  logic              s_w_valid,
  output logic              s_w_ready,
  input  logic [DATA_W-1:0] s_w_data,
  input  logic [STRB_W-1:0] s_w_strb,
  input  logic              s_w_last,
  output logic              s_b_valid,
  input  logic              s_b_ready,
  output logic [ID_W-1:0]   s_b_id,
  output logic [1:0]        s_b_resp,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [2:0]        m_ar_prot,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [2:0]        m_aw_prot,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  output logic [DATA_W-1:0] m_w_data,
  output logic [STRB_W-1:0] m_w_strb,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  input  logic [1:0]        m_b_resp
);

  state_e            state_q, state_d;
  prio_e             prio_q, prio_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        resp_q, resp_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [ADDR_W-1:0] next_addr;
  logic              grant_rd;
  logic              grant_wr;
  logic              aw_acc;
  logic              w_acc;
  logic              unused_wlast;

  // Beat count comes from len only, so WLAST carries no information here.
  assign unused_wlast = s_w_last;

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign grant_rd = s_ar_valid && (!s_aw_valid || (prio_q == PRIO_READ));
  assign grant_wr = s_aw_valid && !grant_rd;
  assign aw_acc   = aw_done_q || m_aw_ready;
  assign w_acc    = w_done_q || m_w_ready;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    s_ar_ready = 1'b0;
    s_aw_ready = 1'b0;
    s_w_ready  = 1'b0;
    s_r_valid  = 1'b0;
    s_r_last   = 1'b0;
    s_b_valid  = 1'b0;
    m_ar_valid = 1'b0;
    m_r_ready  = 1'b0;
    m_aw_valid = 1'b0;
    m_w_valid  = 1'b0;
    m_b_ready  = 1'b0;
    s_r_id     = id_q;
    s_r_data   = m_r_data;
    s_r_resp   = m_r_resp;
    s_b_id     = id_q;
    s_b_resp   = resp_q;
    m_ar_addr  = addr_q;
    m_aw_addr  = addr_q;
    m_ar_prot  = '0;
    m_aw_prot  = '0;
    m_w_data   = wdata_q;
    m_w_strb   = wstrb_q;

    case (state_q)
      ST_IDLE: begin
        s_ar_ready = grant_rd;
        s_aw_ready = grant_wr;
        if (s_ar_valid && s_aw_valid) begin
          prio_d = grant_rd ? PRIO_WRITE : PRIO_READ;
        end
        if (grant_rd) begin
          id_d    = s_ar_id;
          addr_d  = s_ar_addr;
          len_d   = s_ar_len;
          size_d  = s_ar_size;
          burst_d = s_ar_burst;
          cnt_d   = s_ar_len;
          resp_d  = RESP_OKAY;
          state_d = ST_RD_REQ;
        end else if (grant_wr) begin
          id_d    = s_aw_id;
          addr_d  = s_aw_addr;
          len_d   = s_aw_len;
          size_d  = s_aw_size;
          burst_d = s_aw_burst;
          cnt_d   = s_aw_len;
          resp_d  = RESP_OKAY;
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_REQ: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        m_r_ready = s_r_ready;
        s_r_valid = m_r_valid;
        s_r_last  = (cnt_q == 8'd0);
        if (m_r_valid && s_r_ready) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = next_addr;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_DATA: begin
        s_w_ready = 1'b1;
        if (s_w_valid) begin
          wdata_d = s_w_data;
          wstrb_d = s_w_strb;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        // AW and W handshake independently; the done flags remember which one landed.
        m_aw_valid = !aw_done_q;
        m_w_valid  = !w_done_q;
        if (aw_acc && w_acc) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end else begin
          aw_done_d = aw_acc;
          w_done_d  = w_acc;
        end
      end
      ST_WR_RESP: begin
        m_b_ready = 1'b1;
        if (m_b_valid) begin
          resp_d = resp_merge(resp_q, m_b_resp);
          if (cnt_q == 8'd0) begin
            state_d = ST_WR_B;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = next_addr;
            state_d = ST_WR_DATA;
          end
        end
      end
      ST_WR_B: begin
        s_b_valid = 1'b1;
        if (s_b_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      prio_q    <= PRIO_READ;
      cnt_q     <= '0;
      resp_q    <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_mmio_axi4lite_bridge.sv
// Directed scoreboard bench for mmio_axi4lite_bridge: acts as the AXI4 core
// and as a single AXI4-Lite peripheral, servicing one beat at a time.
module tb_mmio_axi4lite_bridge;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  localparam int SIG_S_AR_READY = 0;
  localparam int SIG_S_AW_READY = 1;
  localparam int SIG_S_W_READY  = 2;
  localparam int SIG_S_R_VALID  = 3;
  localparam int SIG_S_B_VALID  = 4;
  localparam int SIG_M_AR_VALID = 5;
  localparam int SIG_M_AW_VALID = 6;
  localparam int SIG_M_B_READY  = 7;

  logic clk = 1'b0;
  logic reset_n;
  logic s_ar_valid, s_ar_ready;
  logic [IW-1:0] s_ar_id;
  logic [AW-1:0] s_ar_addr;
  logic [7:0] s_ar_len;
  logic [2:0] s_ar_size;
  logic [1:0] s_ar_burst;
  logic s_r_valid, s_r_ready;
  logic [IW-1:0] s_r_id;
  logic [DW-1:0] s_r_data;
  logic [1:0] s_r_resp;
  logic s_r_last;
  logic s_aw_valid, s_aw_ready;
  logic [IW-1:0] s_aw_id;
  logic [AW-1:0] s_aw_addr;
  logic [7:0] s_aw_len;
  logic [2:0] s_aw_size;
  logic [1:0] s_aw_burst;
  logic s_w_valid, s_w_ready;
  logic [DW-1:0] s_w_data;
  logic [SW-1:0] s_w_strb;
  logic s_w_last;
  logic s_b_valid, s_b_ready;
  logic [IW-1:0] s_b_id;
  logic [1:0] s_b_resp;
  logic m_ar_valid, m_ar_ready;
  logic [AW-1:0] m_ar_addr;
  logic [2:0] m_ar_prot;
  logic m_r_valid, m_r_ready;
  logic [DW-1:0] m_r_data;
  logic [1:0] m_r_resp;
  logic m_aw_valid, m_aw_ready;
  logic [AW-1:0] m_aw_addr;
  logic [2:0] m_aw_prot;
  logic m_w_valid, m_w_ready;
  logic [DW-1:0] m_w_data;
  logic [SW-1:0] m_w_strb;
  logic m_b_valid, m_b_ready;
  logic [1:0] m_b_resp;

  mmio_axi4lite_bridge #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .ID_W  (IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } w_exp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  logic [AW-1:0] exp_addr_q[$];
  r_exp_t        exp_r_q[$];
  w_exp_t        exp_w_q[$];
  b_exp_t        exp_b_q[$];

  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      SIG_S_AR_READY: return s_ar_ready;
      SIG_S_AW_READY: return s_aw_ready;
      SIG_S_W_READY:  return s_w_ready;
      SIG_S_R_VALID:  return s_r_valid;
      SIG_S_B_VALID:  return s_b_valid;
      SIG_M_AR_VALID: return m_ar_valid;
      SIG_M_AW_VALID: return m_aw_valid;
      SIG_M_B_READY:  return m_b_ready;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [9:0] all_handshake_outs();
    return {s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid,
            m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready};
  endfunction

  // Called just after a negedge; returns at negedge+1 with the signal seen high or the budget spent.
  task automatic wait_for(input int which, input string tag);
    int unsigned n = 0;
    #1;
    while (!sig(which) && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(sig(which)), 64'd1);
  endtask

  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] step;
    logic [AW-1:0] total;
    logic [AW-1:0] base;
    step = AW'(1) << size;
    case (burst)
      2'b00: return a;
      2'b10: begin
        total = (AW'(len) + 1) * step;
        base  = (a / total) * total;
        return (a + step >= base + total) ? base : a + step;
      end
      default: return a + step;
    endcase
  endfunction

  function automatic logic [1:0] model_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd3 || b == 2'd3) return 2'd3;
    if (a == 2'd2 || b == 2'd2) return 2'd2;
    if (a == 2'd1 || b == 2'd1) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [SW-1:0] beat_strb(input int k);
    return SW'(8'hA5 ^ 8'(k * 17));
  endfunction

  task automatic push_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [DW-1:0] dbase, input logic [1:0] rresp);
    logic [AW-1:0] a;
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      exp_addr_q.push_back(a);
      exp_r_q.push_back('{data: dbase + DW'(k), id: id, resp: rresp, last: (k == int'(len))});
      a = model_next(a, len, size, burst);
    end
  endtask

  task automatic push_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [DW-1:0] dbase, input logic [15:0] bresps);
    logic [AW-1:0] a;
    logic [1:0] acc;
    a = addr;
    acc = 2'd0;
    for (int k = 0; k <= int'(len); k++) begin
      exp_addr_q.push_back(a);
      exp_w_q.push_back('{data: dbase + DW'(k), strb: beat_strb(k)});
      acc = model_merge(acc, bresps[2*k +: 2]);
      a = model_next(a, len, size, burst);
    end
    exp_b_q.push_back('{id: id, resp: acc});
  endtask

  task automatic drive_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    s_ar_valid = 1'b1; s_ar_id = id; s_ar_addr = addr;
    s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
  endtask

  task automatic drive_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    s_aw_valid = 1'b1; s_aw_id = id; s_aw_addr = addr;
    s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
  endtask

  task automatic serve_read(input logic [7:0] len, input logic [DW-1:0] dbase, input logic [1:0] rresp);
    r_exp_t er;
    for (int k = 0; k <= int'(len); k++) begin
      wait_for(SIG_M_AR_VALID, "m_ar_valid");
      check("m_ar_addr", 64'(m_ar_addr), 64'(exp_addr_q.pop_front()));
      check("m_ar_prot", 64'(m_ar_prot), 64'd0);
      m_ar_ready = 1'b1;
      @(negedge clk);
      m_ar_ready = 1'b0;
      m_r_valid = 1'b1; m_r_data = dbase + DW'(k); m_r_resp = rresp;
      s_r_ready = 1'b1;
      wait_for(SIG_S_R_VALID, "s_r_valid");
      er = exp_r_q.pop_front();
      check("m_r_ready", 64'(m_r_ready), 64'd1);
      check("s_r_data", s_r_data, er.data);
      check("s_r_id", 64'(s_r_id), 64'(er.id));
      check("s_r_resp", 64'(s_r_resp), 64'(er.resp));
      check("s_r_last", 64'(s_r_last), 64'(er.last));
      @(negedge clk);
      m_r_valid = 1'b0;
      s_r_ready = 1'b0;
    end
  endtask

  task automatic serve_write(input logic [7:0] len, input logic [DW-1:0] dbase, input logic [15:0] bresps,
                             input bit aw_stall, input bit early_last);
    w_exp_t ew;
    b_exp_t eb;
    for (int k = 0; k <= int'(len); k++) begin
      s_w_valid = 1'b1; s_w_data = dbase + DW'(k); s_w_strb = beat_strb(k);
      s_w_last = early_last ? 1'b1 : (k == int'(len));
      wait_for(SIG_S_W_READY, "s_w_ready");
      @(negedge clk);
      s_w_valid = 1'b0;
      wait_for(SIG_M_AW_VALID, "m_aw_valid");
      check("m_w_valid_with_aw", 64'(m_w_valid), 64'd1);
      check("m_aw_addr", 64'(m_aw_addr), 64'(exp_addr_q.pop_front()));
      check("m_aw_prot", 64'(m_aw_prot), 64'd0);
      ew = exp_w_q.pop_front();
      check("m_w_data", m_w_data, ew.data);
      check("m_w_strb", 64'(m_w_strb), 64'(ew.strb));
      if (aw_stall && k == 0) begin
        m_w_ready = 1'b1;
        m_aw_ready = 1'b0;
        @(negedge clk);
        #1;
        check("stall_w_dropped", 64'(m_w_valid), 64'd0);
        check("stall_aw_held", 64'(m_aw_valid), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        check("stall_aw_still", 64'(m_aw_valid), 64'd1);
        m_aw_ready = 1'b1;
      end else begin
        m_aw_ready = 1'b1;
        m_w_ready = 1'b1;
      end
      @(negedge clk);
      m_aw_ready = 1'b0;
      m_w_ready = 1'b0;
      m_b_valid = 1'b1;
      m_b_resp = bresps[2*k +: 2];
      wait_for(SIG_M_B_READY, "m_b_ready");
      @(negedge clk);
      m_b_valid = 1'b0;
    end
    s_b_ready = 1'b1;
    wait_for(SIG_S_B_VALID, "s_b_valid");
    eb = exp_b_q.pop_front();
    check("s_b_id", 64'(s_b_id), 64'(eb.id));
    check("s_b_resp", 64'(s_b_resp), 64'(eb.resp));
    @(negedge clk);
    s_b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [DW-1:0] dbase, input logic [1:0] rresp);
    push_read(id, addr, len, size, burst, dbase, rresp);
    drive_ar(id, addr, len, size, burst);
    wait_for(SIG_S_AR_READY, "s_ar_ready");
    @(negedge clk);
    s_ar_valid = 1'b0;
    serve_read(len, dbase, rresp);
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [DW-1:0] dbase,
                          input logic [15:0] bresps, input bit aw_stall, input bit early_last);
    push_write(id, addr, len, size, burst, dbase, bresps);
    drive_aw(id, addr, len, size, burst);
    wait_for(SIG_S_AW_READY, "s_aw_ready");
    @(negedge clk);
    s_aw_valid = 1'b0;
    serve_write(len, dbase, bresps, aw_stall, early_last);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    s_ar_valid = 0; s_ar_id = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0;
    s_aw_valid = 0; s_aw_id = '0; s_aw_addr = '0; s_aw_len = '0; s_aw_size = '0; s_aw_burst = '0;
    s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_last = 0;
    s_r_ready = 0; s_b_ready = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = '0; m_r_resp = '0;
    m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_resp = '0;
    #1;
    check("reset_outputs", 64'(all_handshake_outs()), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("idle_outputs", 64'(all_handshake_outs()), 64'd0);
    @(negedge clk);

    do_read(4'd5, 32'h6000_0000, 8'd0, 3'd3, 2'b01, 64'h0000_0000_DEAD_BEEF, 2'b00);
    do_write(4'd7, 32'h6000_0010, 8'd3, 3'd3, 2'b01, 64'h0123_4567_89AB_0000, 16'h0000, 1'b1, 1'b0);
    do_read(4'd9, 32'h6000_0038, 8'd3, 3'd3, 2'b10, 64'h1111_0000_0000_0000, 2'b00);
    do_write(4'd2, 32'h6000_0040, 8'd1, 3'd3, 2'b01, 64'h2222_0000_0000_0000, 16'h0002, 1'b0, 1'b1);
    do_write(4'd3, 32'h6000_0080, 8'd1, 3'd3, 2'b01, 64'h3333_0000_0000_0000, 16'h000B, 1'b0, 1'b0);
    do_read(4'd6, 32'h6000_0200, 8'd1, 3'd3, 2'b00, 64'h4444_0000_0000_0000, 2'b10);
    do_read(4'd8, 32'h6000_0300, 8'd2, 3'd2, 2'b11, 64'h5555_0000_0000_0000, 2'b00);

    // Simultaneous requests: read, then write, then read.
    push_read(4'd1, 32'h6000_0400, 8'd0, 3'd3, 2'b01, 64'h6666_0000_0000_0000, 2'b00);
    push_write(4'd10, 32'h6000_0500, 8'd0, 3'd3, 2'b01, 64'h7777_0000_0000_0000, 16'h0000);
    push_read(4'd11, 32'h6000_0600, 8'd0, 3'd3, 2'b01, 64'h8888_0000_0000_0000, 2'b00);
    drive_ar(4'd1, 32'h6000_0400, 8'd0, 3'd3, 2'b01);
    drive_aw(4'd10, 32'h6000_0500, 8'd0, 3'd3, 2'b01);
    #1;
    check("arb1_ar_ready", 64'(s_ar_ready), 64'd1);
    check("arb1_aw_ready", 64'(s_aw_ready), 64'd0);
    @(negedge clk);
    s_ar_valid = 1'b0;
    serve_read(8'd0, 64'h6666_0000_0000_0000, 2'b00);
    drive_ar(4'd11, 32'h6000_0600, 8'd0, 3'd3, 2'b01);
    #1;
    check("arb2_aw_ready", 64'(s_aw_ready), 64'd1);
    check("arb2_ar_ready", 64'(s_ar_ready), 64'd0);
    @(negedge clk);
    s_aw_valid = 1'b0;
    serve_write(8'd0, 64'h7777_0000_0000_0000, 16'h0000, 1'b0, 1'b0);
    #1;
    check("arb3_ar_ready", 64'(s_ar_ready), 64'd1);
    @(negedge clk);
    s_ar_valid = 1'b0;
    serve_read(8'd0, 64'h8888_0000_0000_0000, 2'b00);

    // Reset in the middle of a len=7 read while the first R beat is being offered.
    push_read(4'd4, 32'h6000_0700, 8'd7, 3'd3, 2'b01, 64'h9999_0000_0000_0000, 2'b00);
    drive_ar(4'd4, 32'h6000_0700, 8'd7, 3'd3, 2'b01);
    wait_for(SIG_S_AR_READY, "rst_s_ar_ready");
    @(negedge clk);
    s_ar_valid = 1'b0;
    wait_for(SIG_M_AR_VALID, "rst_m_ar_valid");
    check("rst_m_ar_addr", 64'(m_ar_addr), 64'(exp_addr_q.pop_front()));
    m_ar_ready = 1'b1;
    @(negedge clk);
    m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_data = 64'h9999_0000_0000_0000; s_r_ready = 1'b1;
    #1;
    check("rst_pre_r_valid", 64'(s_r_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_all_dropped", 64'(all_handshake_outs()), 64'd0);
    m_r_valid = 1'b0;
    s_r_ready = 1'b0;
    exp_addr_q.delete();
    exp_r_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_idle", 64'(all_handshake_outs()), 64'd0);
    @(negedge clk);
    do_read(4'd12, 32'h6000_0800, 8'd0, 3'd3, 2'b01, 64'hAAAA_0000_0000_0001, 2'b00);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_axi4lite_bridge.md
Name: mmio_axi4lite_bridge

Overview:
- Sits directly downstream of the RiscVSystem MMIO AXI4 master port (4-bit ID, 32-bit address, 8-bit len, 64-bit data).
- Converts each AXI4 burst into a sequence of single-beat AXI4-Lite transactions for the peripheral interconnect (UART, timers, PLIC-side devices).
- Rebuilds AXI4 responses with the original ID, RLAST and a merged BRESP.
- Handles one burst at a time; reads and writes are arbitrated fairly.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 64, data width on both sides (STRB_W = DATA_W/8)
ID_W, 4, AXI4 ID width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
s_ar_{valid,ready,id,addr,len,size,burst}  in,out,in,in,in,in,in  1,1,ID_W,ADDR_W,8,3,2  AXI4 read address from core
s_r_{valid,ready,id,data,resp,last}  out,in,out,out,out,out  1,1,ID_W,DATA_W,2,1  AXI4 read data to core
s_aw_{valid,ready,id,addr,len,size,burst}  in,out,in,in,in,in,in  1,1,ID_W,ADDR_W,8,3,2  AXI4 write address
s_w_{valid,ready,data,strb,last}  in,out,in,in,in  1,1,DATA_W,STRB_W,1  AXI4 write data
s_b_{valid,ready,id,resp}  out,in,out,out  1,1,ID_W,2  AXI4 write response
m_ar_{valid,ready,addr,prot}  out,in,out,out  1,1,ADDR_W,3  AXI4-Lite read address (prot fixed 3'b000)
m_r_{valid,ready,data,resp}  in,out,in,in  1,1,DATA_W,2  AXI4-Lite read data
m_aw_{valid,ready,addr,prot}  out,in,out,out  1,1,ADDR_W,3  AXI4-Lite write address (prot fixed 3'b000)
m_w_{valid,ready,data,strb}  out,in,out,out  1,1,DATA_W,STRB_W  AXI4-Lite write data
m_b_{valid,ready,resp}  in,out,in  1,1,2  AXI4-Lite write response

Behaviour:
- Reset (async assert, sync deassert by the integrator): FSM=IDLE; every valid/ready output 0; prio=READ; beat counter, merged resp and registered ID/addr/len/size/burst all 0.
- Unused AXI4 fields (lock, cache, prot, qos) are not ported; upstream leaves them unconnected.
- FSM states:
  - IDLE:
    - Exactly one of s_ar_valid / s_aw_valid set: take it.
    - Both set: take the channel named by prio, then flip prio.
    - s_ar_ready or s_aw_ready is asserted combinationally in IDLE for the granted channel only.
    - On handshake, register id/addr/len/size/burst; cnt=len; resp_acc=OKAY.
    - Go to RD_REQ or WR_DATA.
  - RD_REQ: m_ar_valid=1 with cur_addr; on m_ar_ready -> RD_RESP.
  - RD_RESP:
    - m_r_ready = s_r_ready.
    - s_r_valid = m_r_valid; data and resp pass through; s_r_id = reg id; s_r_last = (cnt==0).
    - On handshake: if cnt==0 -> IDLE, else cnt--, advance address -> RD_REQ.
    - Zero-bubble pass-through; no R buffering.
  - WR_DATA: s_w_ready=1; on handshake latch data/strb -> WR_REQ.
  - WR_REQ:
    - m_aw_valid and m_w_valid both raised; each drops independently once accepted (aw_done/w_done flags).
    - When both are accepted -> WR_RESP.
  - WR_RESP:
    - m_b_ready=1; on m_b_valid, resp_acc = max(resp_acc, m_b_resp) with ordering DECERR(3) > SLVERR(2) > OKAY(0).
    - If cnt==0 -> WR_B, else cnt--, advance address -> WR_DATA.
  - WR_B: s_b_valid=1, s_b_id = reg id, s_b_resp = resp_acc; on s_b_ready -> IDLE.
- Address advance, with incr = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr += incr, modulo 2^ADDR_W.
  - WRAP (10): mask = ((len+1)<<size) - 1; addr = (addr & ~mask) | ((addr + incr) & mask).
  - Burst type 11 (reserved): treated as INCR.
- s_w_last is ignored; the beat count comes from len. A premature or late WLAST does not change the beat count.
- Latency:
  - Each read beat costs at least 2 cycles (AR, R).
  - Each write beat costs at least 3 cycles (W, AW/W, B), plus 1 cycle for the final B.
- Ordering: one outstanding lite transaction at any time, so peripheral side effects occur in program order.
- Reset mid-burst aborts immediately. Partially issued lite transactions are not completed, and no response is generated.

Decomposition:
- Package mmio_bridge_pkg holds:
  - burst_e (FIXED/INCR/WRAP)
  - resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - state_e
  - function resp_merge
- Sub-module axi_burst_addr_gen: combinational next-address from addr/len/size/burst. It is shared with future DMA blocks.

Test Plan:
- Single read, ar addr=0x6000_0000, len=0, id=5; lite returns data 0xDEAD_BEEF, OKAY -> one R beat: id=5, rlast=1, data 0xDEAD_BEEF.
- INCR write, awaddr=0x6000_0010, len=3, size=3 -> lite AW addresses 0x10, 0x18, 0x20, 0x28 (offsets); single B with the AW id after the 4th lite B.
- WRAP read, addr=0x6000_0038, len=3, size=3 -> lite addresses 0x38, 0x20, 0x28, 0x30; rlast only on the 4th beat.
- Write burst len=1 where beat 0 gets SLVERR and beat 1 OKAY -> s_b_resp=2. A second case with DECERR then SLVERR -> s_b_resp=3.
- s_ar_valid and s_aw_valid asserted in the same cycle, twice in a row -> first grant read, then write, then read (alternation). Also: m_aw_ready held low 5 cycles while m_w_ready=1 -> m_w_valid drops after 1 cycle and m_aw_valid stays high until accepted.
- reset_n pulsed low during RD_RESP of a len=7 burst -> all valid outputs 0 in the same cycle; after release, a new len=0 read completes normally.
